keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Sequencer for the 3x3 matrix keypad. It drives one-hot rows with a programmable dwell time and samples the columns once per dwell.
- It debounces press and release, and converts each accepted press into a keycode and a digit (1-9).
- The result is delivered as a single-entry valid/ready event to the downstream game/display logic.
- It replaces free-running row rotation plus a separate location decoder with one controlled block.

Parameters:
- DWELL_CYCLES, 50000, clock cycles each row is driven before its columns are sampled; must be >= 3.
- DEBOUNCE_SCANS, 4, consecutive identical samples required to accept a press or a release; must be >= 1.
- REPEAT_SCANS, 64, held-key samples between auto-repeat events; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- scan_en  in  1  1 = scanning runs; 0 = scanning parked
- col  in  3  raw keypad column inputs, active-high, asynchronous to clk
- row  out  3  one-hot row drive
- key_valid  out  1  event pending
- key_ready  in  1  consumer accepts the event
- key_code  out  6  {row[0],row[1],row[2],col[0],col[1],col[2]} of the accepted key
- key_digit  out  4  digit 1..9; 4'hF when no event has been accepted since reset
- overflow  out  1  sticky: a press was dropped because the event register was full
- overflow_clr  in  1  clears overflow
- busy  out  1  1 whenever state != SCAN

Behaviour:
- Reset values (asynchronous): row=3'b001, key_valid=0, key_code=0, key_digit=4'hF, overflow=0, busy=0, state=SCAN, all counters=0.
- col passes through a 2-flop synchronizer to give col_s; all decisions use col_s.
- Dwell counter:
  - Counts 0..DWELL_CYCLES-1.
  - "tick" = the cycle in which count == DWELL_CYCLES-1; the counter then wraps to 0.
  - All sampling happens only on tick.
- Row index r: 0/1/2 maps to row 001/010/100.
- Digit mapping: c = index of the set col_s bit; digit = 3*r + c + 1. Examples: row 001/col 001 -> 1, keycode 100100; row 100/col 100 -> 9, keycode 001001.
- Valid sample: exactly one col_s bit set. Zero bits or two or more bits (ghosting) count as "no key".
- SCAN state:
  - On tick with a valid sample: capture col_s into cand, set deb_cnt=1, go to DEBOUNCE. The row is held.
  - On tick otherwise: advance row 001->010->100->001.
  - If DEBOUNCE_SCANS==1, go straight to PRESS.
- DEBOUNCE state:
  - On tick with col_s == cand: increment deb_cnt; when it reaches DEBOUNCE_SCANS, go to PRESS.
  - On tick with any mismatch: go to SCAN and advance the row.
- PRESS state (exactly one cycle):
  - Write key_code/key_digit and set key_valid, visible the following cycle.
  - If key_valid=1 and key_ready=0 in this cycle: drop the event, set overflow, leave outputs unchanged.
  - Go to HELD with rel_cnt=0.
- HELD state:
  - On tick with col_s == 0: increment rel_cnt; when it reaches DEBOUNCE_SCANS, go to SCAN and advance the row.
  - On tick with nonzero col_s: set rel_cnt=0.
  - A second key pressed while held is ignored.
- Handshake:
  - Transfer occurs when key_valid && key_ready; key_valid then falls next cycle unless PRESS loads a new event in the same cycle.
  - If the transfer and PRESS coincide: load the new event, keep key_valid=1, no overflow.
  - key_code/key_digit are stable while key_valid=1.
- overflow: if set and clear happen in the same cycle, set wins.
- scan_en=0:
  - Takes effect the next cycle: state=SCAN, row=001, dwell/deb/rel counters=0.
  - The pending event and overflow are retained, and the handshake still operates.
- Reset mid-operation returns everything to reset values, discarding any pending event.
- Latency: a stable press is detected at the end of the (DEBOUNCE_SCANS)th dwell on its row, and key_valid rises 2 cycles after that tick.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: in HELD, each tick with col_s == cand increments rep_cnt. When rep_cnt reaches REPEAT_SCANS, the same key is re-emitted with PRESS rules, including overflow, and rep_cnt=0. Any release sample clears rep_cnt.
- Not defined: one event per press, REPEAT_SCANS ignored, no rep_cnt flops.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, PRESS, HELD}
  - ROW_ONEHOT[3] constants
  - DIGIT_NONE=4'hF
  - function onehot3_to_idx
  - function keycode_to_digit
- Sub-module keypad_dwell_timer: parameter DWELL_CYCLES; inputs clk, reset, clr; output tick.

Test Plan:
Bench runs DWELL_CYCLES=4 and DEBOUNCE_SCANS=3.
- No keys, scan_en=1: row rotates 001,010,100 every 4 cycles; key_valid stays 0; key_digit=4'hF.
- Hold col=010 while row=010 for 3 ticks, key_ready=1: exactly one event, key_code=010010, key_digit=5; then release for 3 ticks -> busy falls and row advances to 100.
- col=001 glitch on row 001 for 1 tick only: returns to SCAN, no event.
- Press 1 with key_ready=0, release, then press 9: first event (digit 1) is held, overflow=1, 9 is dropped; assert key_ready -> key_valid falls; pulse overflow_clr -> overflow=0.
- col=011 on row 100: treated as no key, no event; assert reset asynchronously mid-DEBOUNCE -> row=001 and outputs at reset values immediately.
- With KEYPAD_AUTOREPEAT_EN and REPEAT_SCANS=2, hold digit 7 (row 100, col 001) with key_ready=1: first event, then one repeat every 2 ticks, each with key_digit=7.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, row constants and key decode helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESS    = 2'd2,
        HELD     = 2'd3
    } state_t;

    localparam logic [2:0] ROW_ONEHOT [3] = '{3'b001, 3'b010, 3'b100};
    localparam logic [3:0] DIGIT_NONE     = 4'hF;

    function automatic logic [1:0] onehot3_to_idx(input logic [2:0] v);
        case (v)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // keycode layout is {row[0],row[1],row[2],col[0],col[1],col[2]}, so each half is bit-reversed
    function automatic logic [3:0] keycode_to_digit(input logic [5:0] code);
        logic [1:0] r;
        logic [1:0] c;
        r = onehot3_to_idx({code[3], code[4], code[5]});
        c = onehot3_to_idx({code[0], code[1], code[2]});
        return ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - key event valid/ready channel between scanner and consumer
interface keypad_scan_ctrl_if;
    logic       key_valid;
    logic       key_ready;
    logic [5:0] key_code;
    logic [3:0] key_digit;

    modport master (
        output key_valid,
        output key_code,
        output key_digit,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_digit,
        output key_ready
    );
endinterface

// File: rtl/keypad_dwell_timer.sv
// rtl/keypad_dwell_timer.sv - free-running row dwell counter producing one tick per dwell
module keypad_dwell_timer #(
    parameter int DWELL_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DWELL_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 3x3 keypad scan/debounce sequencer; KEYPAD_AUTOREPEAT_EN adds held-key repeat
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DWELL_CYCLES   = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scan_en,
    input  logic [2:0]                col,
    output logic [2:0]                row,
    keypad_scan_ctrl_if.master        key_if,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic                      busy
);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    state_t     state_q, state_d;
    logic [1:0] r_q, r_d;
    logic [2:0] cand_q, cand_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [DW-1:0] rel_cnt_q, rel_cnt_d;
    logic [2:0] col_meta_q, col_meta_d;
    logic [2:0] col_s_q, col_s_d;
    logic       key_valid_q, key_valid_d;
    logic [5:0] key_code_q, key_code_d;
    logic [3:0] key_digit_q, key_digit_d;
    logic       overflow_q, overflow_d;

    logic       tick;
    logic       timer_clr;
    logic       emit;
    logic       advance;
    logic       col_valid;
    logic [2:0] row_cur;
    logic [5:0] new_code;
    logic [DW-1:0] deb_inc;
    logic [DW-1:0] rel_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [RW-1:0] rep_inc;
    assign rep_inc = rep_cnt_q + RW'(1);
`else
    logic unused_repeat;
    assign unused_repeat = (REPEAT_SCANS != 0);
`endif

    keypad_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .tick  (tick)
    );

    assign row_cur   = ROW_ONEHOT[r_q];
    assign row       = row_cur;
    assign busy      = (state_q != SCAN);
    assign overflow  = overflow_q;
    assign col_valid = $onehot(col_s_q);
    assign deb_inc   = deb_cnt_q + DW'(1);
    assign rel_inc   = rel_cnt_q + DW'(1);
    assign new_code  = {row_cur[0], row_cur[1], row_cur[2], cand_q[0], cand_q[1], cand_q[2]};

    assign key_if.key_valid = key_valid_q;
    assign key_if.key_code  = key_code_q;
    assign key_if.key_digit = key_digit_q;

    always_comb begin
        col_meta_d  = col;
        col_s_d     = col_meta_q;
        state_d     = state_q;
        r_d         = r_q;
        cand_d      = cand_q;
        deb_cnt_d   = deb_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        key_digit_d = key_digit_q;
        overflow_d  = overflow_q & ~overflow_clr;
        timer_clr   = ~scan_en;
        emit        = 1'b0;
        advance     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif

        if (scan_en) begin
            case (state_q)
                SCAN: begin
                    if (tick) begin
                        if (col_valid) begin
                            cand_d    = col_s_q;
                            deb_cnt_d = DW'(1);
                            state_d   = (DEBOUNCE_SCANS == 1) ? PRESS : DEBOUNCE;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tick) begin
                        if (col_s_q == cand_q) begin
                            deb_cnt_d = deb_inc;
                            if (deb_inc == DW'(DEBOUNCE_SCANS)) begin
                                state_d = PRESS;
                            end
                        end else begin
                            state_d = SCAN;
                            advance = 1'b1;
                        end
                    end
                end
                PRESS: begin
                    emit      = 1'b1;
                    state_d   = HELD;
                    rel_cnt_d = '0;
                end
                HELD: begin
                    if (tick) begin
                        if (col_s_q == 3'b000) begin
                            rel_cnt_d = rel_inc;
                            if (rel_inc == DW'(DEBOUNCE_SCANS)) begin
                                rel_cnt_d = '0;
                                state_d   = SCAN;
                                advance   = 1'b1;
                            end
                        end else begin
                            rel_cnt_d = '0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (col_s_q == 3'b000) begin
                            rep_cnt_d = '0;
                        end else if (col_s_q == cand_q) begin
                            rep_cnt_d = rep_inc;
                            if (rep_inc == RW'(REPEAT_SCANS)) begin
                                rep_cnt_d = '0;
                                state_d   = PRESS;
                            end
                        end
`endif
                    end
                end
                default: state_d = SCAN;
            endcase
        end else begin
            // parked: the event register and overflow keep their state
            state_d   = SCAN;
            r_d       = 2'd0;
            deb_cnt_d = '0;
            rel_cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_d = '0;
`endif
        end

        if (advance) begin
            r_d = (r_q == 2'd2) ? 2'd0 : r_q + 2'd1;
        end

        if (key_valid_q && key_if.key_ready) begin
            key_valid_d = 1'b0;
        end
        if (emit) begin
            if (key_valid_q && !key_if.key_ready) begin
                overflow_d = 1'b1;
            end else begin
                key_valid_d = 1'b1;
                key_code_d  = new_code;
                key_digit_d = keycode_to_digit(new_code);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            r_q         <= 2'd0;
            cand_q      <= 3'b000;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            col_meta_q  <= 3'b000;
            col_s_q     <= 3'b000;
            key_valid_q <= 1'b0;
            key_code_q  <= 6'd0;
            key_digit_q <= DIGIT_NONE;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            cand_q      <= cand_d;
            deb_cnt_q   <= deb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            col_meta_q  <= col_meta_d;
            col_s_q     <= col_s_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_digit_q <= key_digit_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl driven by a physical keypad model
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;
    localparam int DWELL = 4;
    localparam int DEB   = 3;
    localparam int REP   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_en = 1'b1;
    logic       overflow_clr = 1'b0;
    logic [2:0] col;
    logic [2:0] row;
    logic       overflow;
    logic       busy;
    logic [8:0] keys = 9'd0;
    logic       rand_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [9:0] obs_q[$];
    int         obs_t[$];
    logic [9:0] exp_q[$];

    keypad_scan_ctrl_if ifc();

    keypad_scan_ctrl #(
        .DWELL_CYCLES   (DWELL),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .scan_en      (scan_en),
        .col          (col),
        .row          (row),
        .key_if       (ifc),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // key k = 3*r + c closes row r onto column c
    always_comb begin
        col = 3'b000;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (keys[3*r + c] && row[r]) col[c] = 1'b1;
    end

    always @(negedge clk) begin
        if (!reset && ifc.key_valid && ifc.key_ready) begin
            obs_q.push_back({ifc.key_code, ifc.key_digit});
            obs_t.push_back(cyc);
        end
    end

    function automatic logic [9:0] expect_evt(input int d);
        int r;
        int c;
        logic [5:0] code;
        r = (d - 1) / 3;
        c = (d - 1) % 3;
        code = 6'(1 << (5 - r)) | 6'(1 << (2 - c));
        return {code, 4'(d)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) ifc.key_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_row(input logic [2:0] target, input int budget, input string tag);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            if (row == target) found = 1;
        end
        check(tag, 32'(found), 1);
    endtask

    // sel: 0 = key_valid high, 1 = busy low, 2 = overflow high
    task automatic wait_cond(input int sel, input int budget, input string tag);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            case (sel)
                0: found = ifc.key_valid;
                1: found = !busy;
                default: found = overflow;
            endcase
        end
        check(tag, 32'(found), 1);
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_evt"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int rr;
        int cc;
        int d;
        bit busy_seen;

        ifc.key_ready = 1'b1;
        #12;
        check("rst_row", 32'(row), 32'b001);
        check("rst_valid", 32'(ifc.key_valid), 0);
        check("rst_code", 32'(ifc.key_code), 0);
        check("rst_digit", 32'(ifc.key_digit), 32'hF);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // idle rotation: one row step per dwell
        step(3);
        check("rot_hold", 32'(row), 32'b001);
        step(1);
        check("rot_010", 32'(row), 32'b010);
        step(4);
        check("rot_100", 32'(row), 32'b100);
        step(4);
        check("rot_001", 32'(row), 32'b001);
        check("rot_valid", 32'(ifc.key_valid), 0);
        check("rot_digit", 32'(ifc.key_digit), 32'hF);

        // parking resets the row and restarts the dwell
        step(4);
        scan_en = 1'b0;
        step(1);
        check("park_row", 32'(row), 32'b001);
        step(6);
        check("park_stay", 32'(row), 32'b001);
        scan_en = 1'b1;
        step(3);
        check("unpark_hold", 32'(row), 32'b001);
        step(1);
        check("unpark_row", 32'(row), 32'b010);

        // key 5, exact latency and release
        keys = 9'd1 << 4;
        step(12);
        check("k5_pre_valid", 32'(ifc.key_valid), 0);
        check("k5_busy", 32'(busy), 1);
        step(1);
        check("k5_valid", 32'(ifc.key_valid), 1);
        check("k5_code", 32'(ifc.key_code), 32'b010010);
        check("k5_digit", 32'(ifc.key_digit), 5);
        exp_q.push_back(expect_evt(5));
        keys = 9'd0;
        step(1);
        check("k5_drop", 32'(ifc.key_valid), 0);
        step(9);
        check("k5_rel_busy", 32'(busy), 1);
        check("k5_rel_row", 32'(row), 32'b010);
        step(1);
        check("k5_idle", 32'(busy), 0);
        check("k5_adv", 32'(row), 32'b100);
        compare_events("k5");

        // single-tick glitch on key 1
        step(4);
        check("gl_row", 32'(row), 32'b001);
        keys = 9'd1;
        step(4);
        check("gl_busy", 32'(busy), 1);
        keys = 9'd0;
        step(3);
        check("gl_hold", 32'(row), 32'b001);
        step(1);
        check("gl_idle", 32'(busy), 0);
        check("gl_adv", 32'(row), 32'b010);
        compare_events("glitch");

        // back-pressure: 1 is held, 9 is dropped
        ifc.key_ready = 1'b0;
        wait_row(3'b001, 12, "ov_row1");
        keys = 9'd1;
        wait_cond(0, 40, "ov_valid1");
        check("ov_digit1", 32'(ifc.key_digit), 1);
        exp_q.push_back(expect_evt(1));
        keys = 9'd0;
        wait_cond(1, 40, "ov_idle1");
        wait_row(3'b100, 12, "ov_row9");
        keys = 9'd1 << 8;
        wait_cond(2, 40, "ov_set");
        check("ov_keep_valid", 32'(ifc.key_valid), 1);
        check("ov_keep_code", 32'(ifc.key_code), 32'b100100);
        check("ov_keep_digit", 32'(ifc.key_digit), 1);
        keys = 9'd0;
        wait_cond(1, 40, "ov_idle9");
        ifc.key_ready = 1'b1;
        step(1);
        check("ov_drain", 32'(ifc.key_valid), 0);
        check("ov_sticky", 32'(overflow), 1);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        check("ov_clr", 32'(overflow), 0);
        compare_events("ovf");

        // two keys in one row read as no key
        wait_row(3'b100, 12, "gh_row");
        keys = (9'd1 << 6) | (9'd1 << 7);
        busy_seen = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            busy_seen |= busy;
        end
        check("gh_busy", 32'(busy_seen), 0);
        keys = 9'd0;
        compare_events("ghost");

        // async reset while debouncing key 5
        wait_row(3'b010, 12, "ar_row");
        keys = 9'd1 << 4;
        step(5);
        check("ar_deb", 32'(busy), 1);
        #3;
        reset = 1'b1;
        #1;
        check("ar_row_rst", 32'(row), 32'b001);
        check("ar_valid", 32'(ifc.key_valid), 0);
        check("ar_digit", 32'(ifc.key_digit), 32'hF);
        check("ar_busy", 32'(busy), 0);
        keys = 9'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // randomized presses and same-row ghosts against the keypad rules
        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 3);
            step($urandom_range(0, 11));
            rand_ready = 1'b1;
            if (kind == 0) begin
                rr = $urandom_range(0, 2);
                cc = $urandom_range(0, 2);
                keys = (9'd1 << (3*rr + cc)) | (9'd1 << (3*rr + (cc + 1) % 3));
                step(40);
            end else begin
                d = $urandom_range(1, 9);
                keys = 9'd1 << (d - 1);
                wait_cond(0, 50, "rnd_valid");
                exp_q.push_back(expect_evt(d));
            end
            keys = 9'd0;
            rand_ready = 1'b0;
            ifc.key_ready = 1'b1;
            step(24);
            check("rnd_idle", 32'(busy), 0);
        end
        compare_events("rnd");

`ifdef KEYPAD_AUTOREPEAT_EN
        wait_row(3'b100, 12, "rep_row");
        keys = 9'd1 << 6;
        wait_cond(0, 40, "rep_first");
        step(40);
        keys = 9'd0;
        step(24);
        check("rep_count", 32'(obs_q.size() >= 3), 1);
        for (int i = 0; i < 3 && i < obs_q.size(); i++)
            check("rep_evt", 32'(obs_q[i]), 32'(expect_evt(7)));
        if (obs_t.size() >= 3) begin
            check("rep_gap1", 32'(obs_t[1] - obs_t[0]), 32'(REP * DWELL));
            check("rep_gap2", 32'(obs_t[2] - obs_t[1]), 32'(REP * DWELL));
        end
        obs_q.delete();
        obs_t.delete();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
